// File: rtl/swap_pkg.sv
// ---------------------------------------------------------------------------
// swap_pkg
// Shared definitions for the swap engine: FSM state encoding, the externally
// visible step codes, the operation mode constants and a state-to-step helper.
// ---------------------------------------------------------------------------
package swap_pkg;

    // Engine states. CPY is the single-cycle copy state; the other three
    // non-idle states form the swap sequence through the temp register.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CAP  = 3'd1,
        ST_WRA  = 3'd2,
        ST_WRB  = 3'd3,
        ST_CPY  = 3'd4
    } state_e;

    // Step codes seen by the outside world. CPY shares code 3 with WRB
    // because both are "write the destination entry" steps.
    localparam logic [1:0] STEP_IDLE = 2'd0;
    localparam logic [1:0] STEP_CAP  = 2'd1;
    localparam logic [1:0] STEP_WRA  = 2'd2;
    localparam logic [1:0] STEP_WRB  = 2'd3;
    localparam logic [1:0] STEP_CPY  = 2'd3;

    localparam logic MODE_SWAP = 1'b0;
    localparam logic MODE_COPY = 1'b1;

    function automatic logic [1:0] step_of(input state_e s);
        logic [1:0] code;
        case (s)
            ST_CAP:  code = STEP_CAP;
            ST_WRA:  code = STEP_WRA;
            ST_WRB:  code = STEP_WRB;
            ST_CPY:  code = STEP_CPY;
            default: code = STEP_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/swap_regfile.sv
// ---------------------------------------------------------------------------
// swap_regfile
// DEPTH x WIDTH register file with one synchronous write port and two
// combinational read ports. All entries clear asynchronously on reset_n.
// Out-of-range write addresses are ignored; out-of-range reads return 0.
//
// Ports:
//   clk, reset_n        clock, async active-low reset
//   we, waddr, wdata    write port (already muxed host/engine by the caller)
//   src_addr, src_data  engine read port
//   ext_addr, ext_data  external read port
// ---------------------------------------------------------------------------
module swap_regfile #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    src_addr,
    output logic [WIDTH-1:0] src_data,
    input  logic [AW-1:0]    ext_addr,
    output logic [WIDTH-1:0] ext_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // DEPTH need not be a power of two, so every address is range-checked.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we && (32'(waddr) < DEPTH)) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign src_data = (32'(src_addr) < DEPTH) ? mem_q[src_addr] : '0;
    assign ext_data = (32'(ext_addr) < DEPTH) ? mem_q[ext_addr] : '0;

endmodule

// File: rtl/swap_engine.sv
// ---------------------------------------------------------------------------
// swap_engine
// Swaps two register-file entries (via a temp register) or copies one entry
// onto another, under a req/ready handshake, with done/err pulses. A host
// write port and a combinational read port give access while idle.
//
// Handshake: a request is accepted at a rising edge where req=1 and ready=1.
// ready is high exactly when the engine is idle; there is no queueing, so the
// requester holds req until it sees ready. Addresses are checked and latched
// at acceptance; an out-of-range address is rejected with a one-cycle err
// pulse and no register-file change. done is a one-cycle pulse in the first
// idle cycle after the final write, and a new request may be accepted then.
//
// Ports:
//   clk, reset_n              clock, async active-low reset
//   req, mode, addr_a, addr_b request (mode 0 = SWAP a<->b, 1 = COPY a->b)
//   ready, done, err          handshake status
//   wr_en, wr_addr, wr_data   host write (only honoured while idle)
//   rd_addr, rd_data          combinational read
//   step, w                   current step code and internal write strobe
// ---------------------------------------------------------------------------
module swap_engine
    import swap_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req,
    input  logic             mode,
    input  logic [AW-1:0]    addr_a,
    input  logic [AW-1:0]    addr_b,
    output logic             ready,
    output logic             done,
    output logic             err,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [1:0]       step,
    output logic             w
);

    state_e           state_q, state_d;
    logic [AW-1:0]    a_q, a_d;
    logic [AW-1:0]    b_q, b_d;
    logic [WIDTH-1:0] tmp_q, tmp_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             accept;
    logic             addr_bad;
    logic             rf_we;
    logic [AW-1:0]    rf_waddr;
    logic [WIDTH-1:0] rf_wdata;
    logic [AW-1:0]    src_addr;
    logic [WIDTH-1:0] src_data;

    assign ready    = (state_q == ST_IDLE);
    assign accept   = req && ready;
    assign addr_bad = (32'(addr_a) >= DEPTH) || (32'(addr_b) >= DEPTH);

    // The mode is captured by the path the FSM takes out of IDLE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        tmp_d   = tmp_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && !addr_bad) begin
                    a_d     = addr_a;
                    b_d     = addr_b;
                    state_d = (mode == MODE_COPY) ? ST_CPY : ST_CAP;
                end
            end
            ST_CAP: begin
                tmp_d   = src_data;
                state_d = ST_WRA;
            end
            ST_WRA:  state_d = ST_WRB;
            ST_WRB:  state_d = ST_IDLE;
            ST_CPY:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign done_d = (state_q == ST_WRB) || (state_q == ST_CPY);
    assign err_d  = accept && addr_bad;

    // WRA reads the second entry; every other step reads the first.
    assign src_addr = (state_q == ST_WRA) ? b_q : a_q;

    // Host owns the write port while idle; the engine owns it otherwise.
    always_comb begin
        rf_we    = ready && wr_en;
        rf_waddr = wr_addr;
        rf_wdata = wr_data;
        case (state_q)
            ST_WRA: begin
                rf_we    = 1'b1;
                rf_waddr = a_q;
                rf_wdata = src_data;
            end
            ST_WRB: begin
                rf_we    = 1'b1;
                rf_waddr = b_q;
                rf_wdata = tmp_q;
            end
            ST_CPY: begin
                rf_we    = 1'b1;
                rf_waddr = b_q;
                rf_wdata = src_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            tmp_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tmp_q   <= tmp_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    swap_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .clk      (clk),
        .reset_n  (reset_n),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .src_addr (src_addr),
        .src_data (src_data),
        .ext_addr (rd_addr),
        .ext_data (rd_data)
    );

    assign done = done_q;
    assign err  = err_q;
    assign step = step_of(state_q);
    assign w    = (step != STEP_IDLE);

endmodule

// File: doc/swap_engine.md
# swap_engine

Parametrised successor to the two-entry memory swap controller. It holds a DEPTH x WIDTH register file and exchanges any two entries (mode SWAP) or copies one entry onto another (mode COPY) through an internal temp register. Each operation is a req/ready handshake with a done pulse. A host write port and a combinational read port give access while idle. It sits between the control sequencer and the datapath that consumes the register file.

## Interface
Parameters:
- WIDTH, 8, data bits per entry
- DEPTH, 4, number of entries (>= 2, need not be a power of 2)
- AW, $clog2(DEPTH), address width (derived; do not override)

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  1  operation request
- mode  in  1  0 = SWAP (A<->B), 1 = COPY (A->B)
- addr_a  in  AW  source/first entry
- addr_b  in  AW  destination/second entry
- ready  out  1  engine idle, request accepted this cycle if req=1
- done  out  1  one-cycle pulse, operation complete
- err  out  1  one-cycle pulse, request rejected (address >= DEPTH)
- wr_en  in  1  host write strobe
- wr_addr  in  AW  host write address
- wr_data  in  WIDTH  host write data
- rd_addr  in  AW  read address
- rd_data  out  WIDTH  combinational mem[rd_addr]; 0 if rd_addr >= DEPTH
- step  out  2  current step code (0 idle, 1 capture, 2 write A, 3 write B)
- w  out  1  internal write strobe, 1 when step != 0

## Operation
- States: IDLE, CAP (tmp <= mem[a]), WRA (mem[a] <= mem[b]), WRB (mem[b] <= tmp), CPY (mem[b] <= mem[a]).
- step encoding: IDLE=0, CAP=1, WRA=2, WRB=3, CPY=3.
- SWAP path: IDLE -> CAP -> WRA -> WRB -> IDLE. COPY path: IDLE -> CPY -> IDLE.
- Request acceptance: req=1 and ready=1 at a rising edge. addr_a, addr_b and mode are latched at that edge and held until the operation completes. Input changes while busy have no effect.
- ready = (state == IDLE). req while busy is ignored; there is no queueing, so the requester holds req until it sees ready.
- Rejection: if addr_a or addr_b >= DEPTH at acceptance, the engine stays in IDLE, pulses err the next cycle and leaves mem unchanged.
- addr_a == addr_b: the operation still runs the full sequence. Contents are unchanged and done pulses as normal.
- Host write: performed only when ready=1. wr_en while busy is dropped silently. wr_addr >= DEPTH is ignored.
- wr_en and an accepted req in the same cycle: the write lands at that edge, so the operation sees the written value.
- Reset (async, any time, including mid-operation):
  - state = IDLE
  - all mem entries and tmp = 0
  - latched addrs = 0
  - outputs: ready=1, done=0, err=0, step=0, w=0
  - the aborted operation produces no done.

## Timing
- Accept at edge E0 (end of cycle T).
- SWAP:
  - CAP during T+1
  - WRA during T+2 (mem[a] updates at its end)
  - WRB during T+3
  - IDLE at T+4 with done=1 and ready=1
  - latency from accept to done is 4 cycles
- COPY: CPY during T+1; done=1 at T+2.
- done and err are registered pulses lasting exactly 1 cycle.
- Back-to-back: a new req can be accepted in the done cycle. Throughput is 1 SWAP per 4 cycles and 1 COPY per 2 cycles.
- rd_data is combinational from current mem and reflects a write in the cycle after its edge.
- w=1 for 3 cycles per SWAP and 1 cycle per COPY.

## Structure
- Package swap_pkg:
  - state enum (IDLE, CAP, WRA, WRB, CPY)
  - step code constants
  - mode constants (MODE_SWAP=0, MODE_COPY=1)
- Sub-module swap_regfile (DEPTH x WIDTH):
  - one write port muxed between host and engine
  - two async read ports (engine source, external rd_addr)
  - async clear on reset_n
- Top holds the FSM, address/mode latches, tmp, and the done/err registers.

## Test plan
- Reset, then write mem = {0x11,0x22,0x33,0x44}. SWAP a=0, b=3 -> done at T+4, mem = {0x44,0x22,0x33,0x11}, w high exactly 3 cycles, step sequence 1,2,3,0.
- COPY a=1, b=2 -> done at T+2, mem[2]=0x22, mem[1] unchanged, no other entry touched.
- SWAP a=b=2 -> done at T+4, contents unchanged. Then back-to-back SWAP accepted in the done cycle -> second done 4 cycles later.
- DEPTH=5: SWAP with addr_b=6 -> err pulse next cycle, no done, ready stays 1, mem unchanged. wr_en during busy -> write dropped.
- Assert reset_n low during WRA -> state IDLE and mem all zero immediately, ready=1, no done afterwards. Fresh SWAP after release completes normally.
- wr_en (addr 0, 0xAA) with an accepted SWAP a=0, b=1 in the same cycle -> after done, mem[1]=0xAA.
